// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the adder scheduler: operand width, FSM states, op codes.
package adder_sched_pkg;

  localparam int WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow: both adder inputs share a sign that the sum does not.
  function automatic logic signed_ovf(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

endpackage

// File: rtl/adder_scheduler_if.sv
// Requester-facing bundle of the adder scheduler; master = requesters, slave = scheduler.
interface adder_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 7
);
  // Handshakes: a request transfers on a clock edge where req_valid[i] and
  // req_ready[i] are both 1; req_valid and operands must stay stable until then.
  // A response transfers on an edge where resp_valid[i] and resp_ack[i] are both 1.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ack;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_cout;
  logic                  resp_ovf;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ack,
    input  req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ack,
    output req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, busy
  );
endinterface

// File: rtl/Adder.sv
// 7-bit ripple-carry adder with carry-in and carry-out; the single shared arithmetic unit.
module Adder (
  input  logic [6:0] a,
  input  logic [6:0] b,
  input  logic       cin,
  output logic [6:0] sum,
  output logic       cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 7; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_scheduler.sv
// Time-shares one Adder among NREQ requesters: round-robin accept, one op in flight,
// result returned through a valid/ack response.
module adder_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_scheduler_if.slave        bus,
  output adder_sched_pkg::state_e state_dbg
);
  import adder_sched_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (WIDTH != adder_sched_pkg::WIDTH) begin : g_width_check
    $error("adder_scheduler: WIDTH must equal the Adder width");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
    $error("adder_scheduler: NREQ must be in 2..8");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;

  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     win_idx;
  logic [WIDTH-1:0]  add_b, add_sum;
  logic              add_cout;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .en    (state_q == IDLE),
    .grant (grant),
    .idx   (win_idx)
  );

  // Adder sees registered operands only, so requester changes after accept cannot leak in.
  assign add_b = (op_q == OP_ADD) ? b_q : ~b_q;

  Adder u_adder (
    .a    (a_q),
    .b    (add_b),
    .cin  (op_q == OP_SUB),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ack[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    resp_valid_d = resp_valid_q;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d     = bus.req_a[int'(win_idx)*WIDTH +: WIDTH];
          b_d     = bus.req_b[int'(win_idx)*WIDTH +: WIDTH];
          op_d    = bus.req_op[win_idx];
          owner_d = win_idx;
          if (int'(win_idx) == NREQ - 1) rr_ptr_d = '0;
          else                           rr_ptr_d = win_idx + PW'(1);
        end
      end
      EXEC: begin
        sum_d                 = add_sum;
        cout_d                = add_cout;
        ovf_d                 = signed_ovf(a_q, add_b, add_sum);
        resp_valid_d          = '0;
        resp_valid_d[owner_q] = 1'b1;
      end
      RESP: begin
        if (bus.resp_ack[owner_q]) resp_valid_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_cout  = cout_q;
  assign bus.resp_ovf   = ovf_q;
  assign bus.busy       = busy_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler: directed arithmetic/arbitration cases plus random traffic,
// every cycle compared against an operation-level reference model.
module tb_adder_scheduler;
  import adder_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] valid_v = '0;
  logic [N-1:0] op_v    = '0;
  logic [N-1:0] ack_v   = '0;
  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic         auto_ack = 1'b0;
  state_e       state_dbg;

  adder_scheduler_if #(.NREQ(N), .WIDTH(W)) bus ();

  assign bus.req_valid = valid_v;
  assign bus.req_op    = op_v;
  assign bus.resp_ack  = auto_ack ? bus.resp_valid : ack_v;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.req_a[g*W +: W] = a_v[g];
    assign bus.req_b[g*W +: W] = b_v[g];
  end

  adder_scheduler #(.NREQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (operation level) ----------------
  int m_active = 0, m_resp = 0, m_owner = 0, m_ptr = 0;
  int p_sum = 0, p_cout = 0, p_ovf = 0;
  int o_sum = 0, o_cout = 0, o_ovf = 0;
  logic         s_rst = 1'b1;
  logic [N-1:0] s_valid = '0, s_op = '0, s_ack = '0;
  logic [W-1:0] s_a [N];
  logic [W-1:0] s_b [N];
  int g_idx[$];
  int g_cyc[$];

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic void calc(input int op, input int a, input int b);
    int sa, sb, full, r;
    sa = (a >= 64) ? a - 128 : a;
    sb = (b >= 64) ? b - 128 : b;
    if (op == 0) begin full = a + b;       r = sa + sb; end
    else         begin full = a + 128 - b; r = sa - sb; end
    p_sum  = full % 128;
    p_cout = (full >= 128) ? 1 : 0;
    p_ovf  = (r > 63 || r < -64) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int w;
    if (s_rst) begin
      m_active = 0; m_resp = 0; m_ptr = 0;
      o_sum = 0; o_cout = 0; o_ovf = 0;
    end else if (m_active != 0 && m_resp == 0) begin
      m_resp = 1;
      o_sum = p_sum; o_cout = p_cout; o_ovf = p_ovf;
    end else if (m_active != 0) begin
      if (s_ack[m_owner]) begin m_active = 0; m_resp = 0; end
    end else begin
      w = winner(s_valid, m_ptr);
      if (w >= 0) begin
        m_active = 1;
        m_owner  = w;
        m_ptr    = (w + 1) % N;
        calc(int'(s_op[w]), int'(s_a[w]), int'(s_b[w]));
      end
    end
  end

  // Compare every cycle, then sample inputs for the next model step.
  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_rdy, exp_rv;
    state_e exp_st;
    exp_rdy = '0;
    exp_rv  = '0;
    if (m_active == 0) begin
      w = winner(valid_v, m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    if (m_resp != 0) exp_rv[m_owner] = 1'b1;
    exp_st = (m_active == 0) ? IDLE : ((m_resp != 0) ? RESP : EXEC);
    if (cyc > 0) begin
      chk("model req_ready", int'(bus.req_ready), int'(exp_rdy));
      chk("model resp_valid", int'(bus.resp_valid), int'(exp_rv));
      chk("model busy", int'(bus.busy), m_active);
      chk("model state", int'(state_dbg), int'(exp_st));
      chk("model resp_sum", int'(bus.resp_sum), o_sum);
      chk("model resp_cout", int'(bus.resp_cout), o_cout);
      chk("model resp_ovf", int'(bus.resp_ovf), o_ovf);
      if (!rst && bus.req_ready != '0) begin
        for (int i = 0; i < N; i++)
          if (bus.req_ready[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
      end
    end
    s_rst   = rst;
    s_valid = valid_v;
    s_op    = op_v;
    s_ack   = bus.resp_ack;
    for (int i = 0; i < N; i++) begin s_a[i] = a_v[i]; s_b[i] = b_v[i]; end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic reset_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1 auto_ack = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 30) begin @(negedge clk); n++; end
    chk("drain busy", int'(bus.busy), 0);
    @(posedge clk); #1 auto_ack = 1'b0;
  endtask

  task automatic do_op(input int i, input int op, input int a, input int b,
                       input int es, input int ec, input int eo, input string tag);
    int n;
    @(posedge clk); #1;
    op_v[i] = op[0]; a_v[i] = W'(a); b_v[i] = W'(b); valid_v[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[i] && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, int'(bus.req_ready[i]), 1);
    @(posedge clk); #1 valid_v[i] = 1'b0;
    @(negedge clk);
    chk({tag, " ready pulse"}, int'(bus.req_ready), 0);
    chk({tag, " busy"}, int'(bus.busy), 1);
    n = 1;
    while (!bus.resp_valid[i] && n < 20) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, 2);
    chk({tag, " sum"}, int'(bus.resp_sum), es);
    chk({tag, " cout"}, int'(bus.resp_cout), ec);
    chk({tag, " ovf"}, int'(bus.resp_ovf), eo);
    @(posedge clk); #1 ack_v[i] = 1'b1;
    @(posedge clk); #1 ack_v[i] = 1'b0;
    @(negedge clk);
    chk({tag, " idle busy"}, int'(bus.busy), 0);
    chk({tag, " idle resp_valid"}, int'(bus.resp_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int exp_order[6];
    logic [N-1:0] rdy;
    logic t;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset resp_valid", int'(bus.resp_valid), 0);
    chk("reset sum", int'(bus.resp_sum), 0);
    chk("reset state", int'(state_dbg), int'(IDLE));

    do_op(0, 0, 3, 2, 5, 0, 0, "add3+2");
    for (int k = 0; k < 7; k++) do_op(0, 0, 0, 1 << k, 1 << k, 0, 0, "bitwalk");
    do_op(1, 0, 0, 16, 16, 0, 0, "add0+16");
    do_op(1, 1, 100, 1, 99, 1, 0, "sub100-1");
    do_op(1, 1, 1, 2, 127, 0, 0, "sub1-2");
    do_op(1, 0, 63, 1, 64, 0, 1, "add63+1");
    do_op(1, 0, 127, 1, 0, 1, 0, "add127+1");
    do_op(2, 1, 0, 64, 64, 0, 1, "sub0-m64");

    // Fairness with all requesters busy and immediate acks.
    reset_pulse();
    g_idx.delete(); g_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      a_v[i] = W'($urandom_range(0, 127)); b_v[i] = W'($urandom_range(0, 127));
      op_v[i] = 1'($urandom_range(0, 1));
    end
    valid_v = '1; auto_ack = 1'b1;
    n = 0;
    while (g_idx.size() < 6 && n < 100) begin @(negedge clk); n++; end
    chk("fair grant count", (g_idx.size() >= 6) ? 1 : 0, 1);
    if (g_idx.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("fair grant order", g_idx[k], exp_order[k]);
      chk("fair period", g_cyc[5] - g_cyc[0], 15);
    end
    @(posedge clk); #1 valid_v = '0;
    drain();

    // Reset while requester 2 is executing.
    @(posedge clk); #1 op_v[2] = 1'b0; a_v[2] = 7'd10; b_v[2] = 7'd5; valid_v[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[2] && n < 20) begin @(negedge clk); n++; end
    chk("rst-exec ready", int'(bus.req_ready[2]), 1);
    @(posedge clk); #1 valid_v[2] = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst-exec in exec", int'(state_dbg), int'(EXEC));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst-exec idle", int'(state_dbg), int'(IDLE));
    chk("rst-exec busy", int'(bus.busy), 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst-exec no resp", int'(bus.resp_valid[2]), 0);
    end
    do_op(3, 1, 50, 20, 30, 1, 0, "post-rst req3");

    // Held ack with non-owner ack noise; other requesters wait.
    @(posedge clk); #1 op_v[0] = 1'b0; a_v[0] = 7'd10; b_v[0] = 7'd20; valid_v[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 valid_v[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 valid_v[1] = 1'b1; valid_v[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      t = k[0];
      @(posedge clk); #1 ack_v = {t, ~t, t, 1'b0};
      @(negedge clk);
      chk("hold resp_valid", int'(bus.resp_valid), 1);
      chk("hold sum", int'(bus.resp_sum), 30);
      chk("hold no grant", int'(bus.req_ready), 0);
    end
    @(posedge clk); #1 ack_v = 4'b0001;
    @(posedge clk); #1 ack_v = '0;
    @(negedge clk);
    chk("hold next grant", int'(bus.req_ready), 2);
    @(posedge clk); #1 valid_v = '0;
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (valid_v[i] && rdy[i]) begin
          valid_v[i] = 1'($urandom_range(0, 1));
          a_v[i] = W'($urandom_range(0, 127)); b_v[i] = W'($urandom_range(0, 127));
          op_v[i] = 1'($urandom_range(0, 1));
        end else if (valid_v[i]) begin
          if ($urandom_range(0, 15) == 0) valid_v[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          a_v[i] = W'($urandom_range(0, 127)); b_v[i] = W'($urandom_range(0, 127));
          op_v[i] = 1'($urandom_range(0, 1));
          valid_v[i] = 1'b1;
        end
      end
      ack_v = N'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    @(posedge clk); #1 valid_v = '0; ack_v = '0; rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_errs++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_scheduler.md
Name: adder_scheduler

Overview:
- Time-shares one 7-bit ripple-carry adder (`Adder`, a 7-bit sum with carry-in and carry-out) among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Supports add and subtract. Subtract is a + ~b + 1, formed by inverting b and setting cin=1.
- Returns sum, carry-out and signed overflow through a valid/ack response handshake.
- Sits between the datapath clients and the single shared `Adder` instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 7, operand width. Fixed by `Adder`; any other value is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i holds an operation.
- req_op  in  NREQ  per requester: 0=add, 1=sub.
- req_a  in  NREQ*WIDTH  operand A, flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  NREQ  one-hot; result is ready for that requester.
- resp_ack  in  NREQ  requester consumes its result.
- resp_sum  out  WIDTH  result.
- resp_cout  out  1  adder carry-out. On sub, 1 means no borrow.
- resp_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clocking: single clock clk; synchronous active-high reset rst.
- Reset (rst=1 at a clock edge, from any state):
  - state goes to IDLE, rr_ptr to 0.
  - req_ready, resp_valid, resp_sum, resp_cout, resp_ovf and busy all go to 0.
  - Any in-flight operation is discarded with no response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - winner = first i with req_valid[i]=1, searching upward from rr_ptr and wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in this cycle only; all other req_ready bits are 0.
  - On the clock edge: latch a, b, op and owner=winner; set rr_ptr=(winner+1) mod NREQ; go to EXEC.
  - No req_valid: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - Adder inputs come from registers only: A=a_r, B = op_r ? ~b_r : b_r, cin=op_r.
  - On the clock edge: register sum and cout, and compute ovf = (A[6]==B[6]) && (sum[6]!=A[6]), using the inverted B for sub.
  - Go to RESP.
- RESP:
  - resp_valid[owner]=1; resp_sum, resp_cout and resp_ovf are stable.
  - When resp_ack[owner]=1 at a clock edge: resp_valid goes to 0 and state goes to IDLE.
  - resp_ack on non-owner bits is ignored.
- Timing:
  - Latency from accept edge to resp_valid is 2 cycles.
  - Minimum period is 3 cycles per operation when ack is immediate.
- Requesters:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - Operand changes after accept have no effect.
  - req_valid dropped without ready is legal; the operation is simply withdrawn.
  - A requester that is in RESP may raise req_valid again. It is considered only after it returns to IDLE, under normal rotation.
- Arithmetic:
  - Results are modulo 2^7.
  - Each sum bit must equal the exact binary sum; no bit may depend on a mismatched operand index.
- Fairness: with all NREQ requesting continuously, each requester is granted once per NREQ operations.
- Outputs: req_ready is combinational from state, rr_ptr and req_valid; all other outputs are registered.

Decomposition:
- Package adder_sched_pkg:
  - WIDTH=7.
  - state enum {IDLE, EXEC, RESP}.
  - op encodings OP_ADD=0, OP_SUB=1.
- Sub-module rr_arbiter, parameterised by NREQ:
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and binary index.
  - Purely combinational; the pointer register stays in adder_scheduler.
- adder_scheduler instantiates rr_arbiter and one `Adder`.

Test Plan:
- Reset, then req0 add a=3, b=2 -> req_ready[0] pulses 1 cycle; 2 cycles later resp_valid[0]=1, sum=5, cout=0, ovf=0; ack -> busy=0 next cycle.
- Per-bit check, a=0 with b=1,2,4,8,16,32,64 (add) -> sum equals b exactly each time; specifically b=16 gives sum=16.
- req1 sub a=100, b=1 -> sum=99, cout=1. Then sub a=1, b=2 -> sum=127, cout=0. Then add 63+1 -> sum=64, ovf=1. Then add 127+1 -> sum=0, cout=1, ovf=0.
- All four req_valid held high with immediate acks -> grant order 0,1,2,3,0,1; each resp_valid appears on the correct single bit.
- Assert rst during EXEC with req2 in flight -> next cycle state is IDLE, no resp_valid[2], rr_ptr=0; a new req3 is then granted and completes normally.
- In RESP, hold ack low for 5 cycles and toggle non-owner ack bits -> result held stable, no new grant; owner ack -> IDLE, and the next grant follows rr_ptr.
